// File: rtl/tile_pixel_fetch.sv
// rtl/tile_pixel_fetch.sv - five-stage tile-map pixel fetch: map RAM -> sprite ROM -> palette -> RGB
module tile_pixel_fetch #(
    parameter int          ORIGIN_X   = 254,
    parameter int          ORIGIN_Y   = 32,
    parameter int          TILE_WIDTH = 32,
    parameter int          MAP_TILES  = 11,
    parameter logic [23:0] BG_COLOR   = 24'h000000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        pix_valid,
    input  logic [3:0]  tileX,
    input  logic [3:0]  tileY,
    input  logic [9:0]  relPos,
    output logic [7:0]  map_addr,
    input  logic [7:0]  map_rdata,
    output logic [17:0] rom_addr,
    input  logic [3:0]  rom_rdata,
    input  logic        pal_we,
    input  logic [3:0]  pal_waddr,
    input  logic [23:0] pal_wdata,
    output logic [7:0]  Red,
    output logic [7:0]  Green,
    output logic [7:0]  Blue,
    output logic        pix_valid_out
);

    localparam logic [31:0] X_LO   = ORIGIN_X;
    localparam logic [31:0] X_HI   = ORIGIN_X + MAP_TILES * TILE_WIDTH;
    localparam logic [31:0] Y_LO   = ORIGIN_Y;
    localparam logic [31:0] Y_HI   = ORIGIN_Y + MAP_TILES * TILE_WIDTH;
    localparam logic [7:0]  MAP_W8 = 8'(MAP_TILES);

    logic [31:0] draw_x_w;
    logic [31:0] draw_y_w;
    logic        in_map;
    logic [7:0]  map_idx;

    logic [7:0]  map_addr_q;
    logic [17:0] rom_addr_q;
    logic [9:0]  relpos_s1_q;
    logic [9:0]  relpos_s2_q;
    logic [3:0]  in_map_q;
    logic [3:0]  valid_q;
    logic [23:0] pal_q [16];
    logic [23:0] rgb_q;
    logic [23:0] rgb_d;
    logic        pix_valid_out_q;

    assign draw_x_w = {22'd0, DrawX};
    assign draw_y_w = {22'd0, DrawY};

    // Tile indices beyond the map are masked purely by the screen-window test.
    assign in_map = pix_valid
                 && (draw_x_w >= X_LO) && (draw_x_w < X_HI)
                 && (draw_y_w >= Y_LO) && (draw_y_w < Y_HI);

    assign map_idx = 8'(({4'd0, tileY} * MAP_W8) + {4'd0, tileX});

    always_comb begin
        rgb_d = BG_COLOR;
        if (!valid_q[3]) begin
            rgb_d = 24'h000000;
        end else if (in_map_q[3] && (rom_rdata != 4'd0)) begin
            rgb_d = pal_q[rom_rdata];
        end
    end

    // Palette lookup reads pal_q before this edge's write lands, so a colliding write shows next cycle.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            map_addr_q      <= 8'd0;
            rom_addr_q      <= 18'd0;
            relpos_s1_q     <= 10'd0;
            relpos_s2_q     <= 10'd0;
            in_map_q        <= 4'd0;
            valid_q         <= 4'd0;
            rgb_q           <= 24'd0;
            pix_valid_out_q <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                pal_q[i] <= {3{8'(i * 17)}};
            end
        end else begin
            map_addr_q      <= map_idx;
            relpos_s1_q     <= relPos;
            relpos_s2_q     <= relpos_s1_q;
            rom_addr_q      <= {map_rdata, relpos_s2_q};
            in_map_q        <= {in_map_q[2:0], in_map};
            valid_q         <= {valid_q[2:0], pix_valid};
            rgb_q           <= rgb_d;
            pix_valid_out_q <= valid_q[3];
            if (pal_we) begin
                pal_q[pal_waddr] <= pal_wdata;
            end
        end
    end

    assign map_addr      = map_addr_q;
    assign rom_addr      = rom_addr_q;
    assign Red           = rgb_q[23:16];
    assign Green         = rgb_q[15:8];
    assign Blue          = rgb_q[7:0];
    assign pix_valid_out = pix_valid_out_q;

endmodule
